// File: rtl/rvb_pkg.sv
// rtl/rvb_pkg.sv - shared constants and types for the rvb bit-manipulation execute units
package rvb_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rvb_state_e;

  // Bit c set means CYCLES=c is supported: 0 is the single-stage build, 1/2/4/8 iterate.
  localparam logic [8:0] CYCLES_LEGAL = 9'b1_0001_0111;

  function automatic logic cycles_legal(input int c);
    if (c < 0 || c > 8) return 1'b0;
    return CYCLES_LEGAL[c[3:0]];
  endfunction

endpackage

// File: rtl/rvb_bmatflip_slice.sv
// rtl/rvb_bmatflip_slice.sv - result-byte slice of the 8x8 bit-matrix transpose
// RVB_BMATFLIP_ANTI_EN adds the anti_i input selecting the anti-transpose.
module rvb_bmatflip_slice #(
  parameter int SLICE_BYTES = 8,
  parameter int IDX_W       = 1
) (
  input  logic [63:0]              mat_i,
  input  logic [IDX_W-1:0]         idx_i,
`ifdef RVB_BMATFLIP_ANTI_EN
  input  logic                     anti_i,
`endif
  output logic [8*SLICE_BYTES-1:0] bytes_o
);

  logic [63:0] full;
  logic [5:0]  base;

  // Result byte i is matrix column i; the anti variant reflects about the other diagonal.
  always_comb begin
    full = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
`ifdef RVB_BMATFLIP_ANTI_EN
        full[8*i+j] = anti_i ? mat_i[8*(7-j)+(7-i)] : mat_i[8*j+i];
`else
        full[8*i+j] = mat_i[8*j+i];
`endif
      end
    end
  end

  assign base    = 6'(idx_i) * 6'(8 * SLICE_BYTES);
  assign bytes_o = full[base +: 8*SLICE_BYTES];

endmodule

// File: rtl/rvb_bmatflip.sv
// rtl/rvb_bmatflip.sv - 8x8 bit-matrix transpose, single-stage (CYCLES=0) or byte-sliced iterative
// RVB_BMATFLIP_ANTI_EN: din_insn14=1 selects the anti-transpose.
module rvb_bmatflip #(
  parameter int CYCLES = 0,
  parameter int XLEN   = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [XLEN-1:0] din_rs1,
  input  logic [XLEN-1:0] din_rs2,
  input  logic            din_insn14,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_rd
);
  import rvb_pkg::*;

  localparam int NSLICE      = (CYCLES == 0) ? 1 : CYCLES;
  localparam int SLICE_BYTES = 8 / NSLICE;
  localparam int CNT_W       = $clog2(NSLICE) + 1;

  if (!cycles_legal(CYCLES)) begin : g_bad_cycles
    $error("rvb_bmatflip: CYCLES must be 0, 1, 2, 4 or 8");
  end
  if (XLEN != rvb_pkg::XLEN) begin : g_bad_xlen
    $error("rvb_bmatflip: XLEN must be 64");
  end

  logic [63:0]              slice_mat;
  logic [CNT_W-1:0]         slice_idx;
  logic [8*SLICE_BYTES-1:0] slice_bytes;
  logic [XLEN-1:0]          rd_q;
`ifdef RVB_BMATFLIP_ANTI_EN
  logic                     slice_anti;
`endif

  rvb_bmatflip_slice #(
    .SLICE_BYTES(SLICE_BYTES),
    .IDX_W      (CNT_W)
  ) u_slice (
    .mat_i  (slice_mat),
    .idx_i  (slice_idx),
`ifdef RVB_BMATFLIP_ANTI_EN
    .anti_i (slice_anti),
`endif
    .bytes_o(slice_bytes)
  );

  assign dout_rd = rd_q;

  if (CYCLES == 0) begin : g_single
    logic valid_q;

    assign din_ready  = !valid_q || dout_ready;
    assign dout_valid = valid_q;
    assign slice_mat  = din_rs1;
    assign slice_idx  = '0;
`ifdef RVB_BMATFLIP_ANTI_EN
    assign slice_anti = din_insn14;
`endif

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= 1'b0;
        rd_q    <= '0;
      end else if (din_valid && din_ready) begin
        valid_q <= 1'b1;
        rd_q    <= slice_bytes;
      end else if (dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end else begin : g_iter
    rvb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      mat_q, mat_d;
    logic [XLEN-1:0]  rd_d;
    logic             accept;
`ifdef RVB_BMATFLIP_ANTI_EN
    logic             anti_q, anti_d;

    assign slice_anti = anti_q;
`endif

    assign slice_mat  = mat_q;
    assign slice_idx  = cnt_q;
    assign dout_valid = (state_q == DONE);

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        mat_q   <= '0;
        rd_q    <= '0;
`ifdef RVB_BMATFLIP_ANTI_EN
        anti_q  <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        mat_q   <= mat_d;
        rd_q    <= rd_d;
`ifdef RVB_BMATFLIP_ANTI_EN
        anti_q  <= anti_d;
`endif
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mat_d     = mat_q;
      rd_d      = rd_q;
`ifdef RVB_BMATFLIP_ANTI_EN
      anti_d    = anti_q;
`endif
      din_ready = 1'b0;
      accept    = 1'b0;
      case (state_q)
        IDLE: begin
          din_ready = 1'b1;
          accept    = din_valid;
        end
        BUSY: begin
          for (int s = 0; s < NSLICE; s++) begin
            if (cnt_q == CNT_W'(s)) rd_d[s*8*SLICE_BYTES +: 8*SLICE_BYTES] = slice_bytes;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NSLICE - 1)) state_d = DONE;
        end
        DONE: begin
          din_ready = dout_ready;
          if (dout_ready) begin
            state_d = IDLE;
            accept  = din_valid;
          end
        end
        default: state_d = IDLE;
      endcase
      // A new operand restarts from a cleared result, also when it arrives on the consume edge.
      if (accept) begin
        state_d = BUSY;
        mat_d   = din_rs1;
        cnt_d   = '0;
        rd_d    = '0;
`ifdef RVB_BMATFLIP_ANTI_EN
        anti_d  = din_insn14;
`endif
      end
    end
  end

`ifdef RVB_BMATFLIP_ANTI_EN
  logic unused_ok;
  assign unused_ok = ^din_rs2;
`else
  logic unused_ok;
  assign unused_ok = ^{din_rs2, din_insn14};
`endif

endmodule

// File: tb/tb_rvb_bmatflip.sv
// tb/tb_rvb_bmatflip.sv - randomized self-checking bench for rvb_bmatflip (CYCLES 0, 4 and 8 instances)
module tb_rvb_bmatflip;

  logic        clock = 1'b0;
  logic        reset;
  logic        din_valid  [3];
  logic        din_ready  [3];
  logic        din_insn14 [3];
  logic        dout_valid [3];
  logic        dout_ready [3];
  logic [63:0] din_rs1    [3];
  logic [63:0] din_rs2    [3];
  logic [63:0] dout_rd    [3];

  int total = 0;
  int bad   = 0;

  int          ncyc    [3] = '{0, 4, 8};
  logic [63:0] vec_in  [4] = '{64'h1, 64'h80, 64'hFF, 64'h8040201008040201};
  logic [63:0] vec_out [4] = '{64'h1, 64'h0100000000000000, 64'h0101010101010101, 64'h8040201008040201};

`ifdef RVB_BMATFLIP_ANTI_EN
  localparam bit ANTI_ON = 1'b1;
`else
  localparam bit ANTI_ON = 1'b0;
`endif

  always #5 clock = ~clock;

  rvb_bmatflip #(.CYCLES(0)) u_c0 (
    .clock(clock), .reset(reset),
    .din_valid(din_valid[0]), .din_ready(din_ready[0]), .din_rs1(din_rs1[0]),
    .din_rs2(din_rs2[0]), .din_insn14(din_insn14[0]),
    .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0]), .dout_rd(dout_rd[0])
  );
  rvb_bmatflip #(.CYCLES(4)) u_c4 (
    .clock(clock), .reset(reset),
    .din_valid(din_valid[1]), .din_ready(din_ready[1]), .din_rs1(din_rs1[1]),
    .din_rs2(din_rs2[1]), .din_insn14(din_insn14[1]),
    .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1]), .dout_rd(dout_rd[1])
  );
  rvb_bmatflip #(.CYCLES(8)) u_c8 (
    .clock(clock), .reset(reset),
    .din_valid(din_valid[2]), .din_ready(din_ready[2]), .din_rs1(din_rs1[2]),
    .din_rs2(din_rs2[2]), .din_insn14(din_insn14[2]),
    .dout_valid(dout_valid[2]), .dout_ready(dout_ready[2]), .dout_rd(dout_rd[2])
  );

  // Reference: view rs1 as an 8x8 grid a[row][col] and read it back column-wise.
  function automatic logic [63:0] model(input logic [63:0] m, input logic insn14);
    logic        a [8][8];
    logic [63:0] r;
    logic        anti;
    anti = 1'b0;
    if (ANTI_ON) anti = insn14;
    for (int row = 0; row < 8; row++)
      for (int col = 0; col < 8; col++)
        a[row][col] = m[8*row + col];
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        r[8*i + j] = anti ? a[7-j][7-i] : a[j][i];
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_accept(input int u, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock);
      ok = din_ready[u];
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_result(input int u, output bit ok);
    ok = dout_valid[u];
    for (int n = 0; n < 100 && !ok; n++) begin
      @(posedge clock); #1;
      ok = dout_valid[u];
    end
  endtask

  task automatic do_op(input int u, input logic [63:0] rs1, input logic insn,
                       input logic [63:0] exp, input string name);
    bit ok;
    din_valid[u]  = 1'b1;
    din_rs1[u]    = rs1;
    din_insn14[u] = insn;
    dout_ready[u] = 1'b0;
    wait_accept(u, ok);
    din_valid[u]  = 1'b0;
    din_rs1[u]    = rand64();
    total++;
    if (!ok) begin bad++; $display("FAIL %s accept: din_ready stayed 0, want 1", name); end
    wait_result(u, ok);
    total++;
    if (!ok || dout_rd[u] !== exp) begin
      bad++;
      $display("FAIL %s: dout_valid=%0b dout_rd=%h, want valid=1 rd=%h", name, dout_valid[u], dout_rd[u], exp);
    end
    dout_ready[u] = 1'b1;
    @(posedge clock); #1;
    dout_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (dout_valid[u] !== 1'b0 || dout_rd[u] !== 64'h0) begin
        bad++;
        $display("FAIL reset_state u%0d: valid=%0b rd=%h, want 0 and 0", u, dout_valid[u], dout_rd[u]);
      end
    end
    reset = 1'b0;
    @(posedge clock); #1;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (din_ready[u] !== 1'b1 || dout_valid[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_release u%0d: din_ready=%0b valid=%0b, want 1 and 0", u, din_ready[u], dout_valid[u]);
      end
    end
  endtask

  task automatic test_single();
    for (int u = 0; u < 3; u++)
      for (int v = 0; v < 4; v++)
        do_op(u, vec_in[v], 1'b0, vec_out[v], $sformatf("single u%0d v%0d", u, v));
  endtask

  task automatic test_latency();
    logic [63:0] r;
    r = rand64();
    dout_ready[1] = 1'b1;
    din_valid[1]  = 1'b1;
    din_rs1[1]    = r;
    din_insn14[1] = 1'b0;
    @(negedge clock);
    total++;
    if (din_ready[1] !== 1'b1) begin bad++; $display("FAIL latency_idle_ready: %0b want 1", din_ready[1]); end
    @(posedge clock); #1;
    din_valid[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      total++;
      if (din_ready[1] !== 1'b0 || dout_valid[1] !== 1'b0) begin
        bad++;
        $display("FAIL latency_busy edge k+%0d: din_ready=%0b valid=%0b, want 0 and 0", c, din_ready[1], dout_valid[1]);
      end
      @(posedge clock); #1;
    end
    total++;
    if (dout_valid[1] !== 1'b1 || dout_rd[1] !== model(r, 1'b0)) begin
      bad++;
      $display("FAIL latency_result: valid=%0b rd=%h, want 1 and %h", dout_valid[1], dout_rd[1], model(r, 1'b0));
    end
    @(posedge clock); #1;
    dout_ready[1] = 1'b0;
  endtask

  task automatic test_back_to_back(input int u);
    logic [63:0] a, b;
    bit ok;
    a = rand64();
    b = rand64();
    din_valid[u] = 1'b1; din_rs1[u] = a; din_insn14[u] = 1'b0; dout_ready[u] = 1'b0;
    wait_accept(u, ok);
    din_valid[u] = 1'b0;
    wait_result(u, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b u%0d first: no result, want valid=1", u); end
    din_valid[u] = 1'b1; din_rs1[u] = b; dout_ready[u] = 1'b1;
    @(negedge clock);
    total++;
    if (din_ready[u] !== 1'b1 || dout_rd[u] !== model(a, 1'b0)) begin
      bad++;
      $display("FAIL b2b u%0d done: din_ready=%0b rd=%h, want 1 and %h", u, din_ready[u], dout_rd[u], model(a, 1'b0));
    end
    @(posedge clock); #1;
    din_valid[u] = 1'b0; din_rs1[u] = rand64(); dout_ready[u] = 1'b0;
    total++;
    if (dout_valid[u] !== 1'b0) begin bad++; $display("FAIL b2b u%0d drop: valid=%0b want 0", u, dout_valid[u]); end
    for (int c = 1; c <= ncyc[u]; c++) begin
      @(posedge clock); #1;
      total++;
      if (dout_valid[u] !== (c == ncyc[u])) begin
        bad++;
        $display("FAIL b2b u%0d edge +%0d: valid=%0b want %0b", u, c, dout_valid[u], (c == ncyc[u]));
      end
    end
    total++;
    if (dout_rd[u] !== model(b, 1'b0)) begin
      bad++;
      $display("FAIL b2b u%0d second: rd=%h want %h", u, dout_rd[u], model(b, 1'b0));
    end
    dout_ready[u] = 1'b1;
    @(posedge clock); #1;
    dout_ready[u] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    din_valid[2] = 1'b1; din_rs1[2] = 64'hFFFF_FFFF_FFFF_FFFF; din_insn14[2] = 1'b0; dout_ready[2] = 1'b0;
    wait_accept(2, ok);
    din_valid[2] = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    dout_ready[2] = 1'b1;
    @(posedge clock); #1;
    total++;
    if (!ok || dout_valid[2] !== 1'b0 || dout_rd[2] !== 64'h0) begin
      bad++;
      $display("FAIL reset_mid: accepted=%0b valid=%0b rd=%h, want 1, 0, 0", ok, dout_valid[2], dout_rd[2]);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (dout_valid[2]) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid_stale: stale result valid=1, want 0"); end
    do_op(2, 64'hFF, 1'b0, 64'h0101010101010101, "reset_mid_next");
  endtask

  task automatic test_backpressure(input int u, input int nops);
    logic [63:0] q [$];
    logic [63:0] hold, exp;
    int          sent, got, cyc;
    bit          stalled;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; hold = '0;
    while (got < nops && cyc < 20000) begin
      din_valid[u]  = (sent < nops) && ($urandom_range(3) != 0);
      din_rs1[u]    = rand64();
      din_rs2[u]    = rand64();
      din_insn14[u] = 1'($urandom_range(1));
      dout_ready[u] = ($urandom_range(7) != 0);
      @(negedge clock);
      if (din_valid[u] && din_ready[u]) begin
        q.push_back(model(din_rs1[u], din_insn14[u]));
        sent++;
      end
      if (stalled) begin
        total++;
        if (dout_valid[u] !== 1'b1 || dout_rd[u] !== hold) begin
          bad++;
          $display("FAIL bp u%0d stall: valid=%0b rd=%h, want 1 and %h", u, dout_valid[u], dout_rd[u], hold);
        end
      end
      stalled = 1'b0;
      if (dout_valid[u]) begin
        if (dout_ready[u]) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL bp u%0d extra: rd=%h, want no result", u, dout_rd[u]);
          end else begin
            exp = q.pop_front();
            if (dout_rd[u] !== exp) begin
              bad++;
              $display("FAIL bp u%0d result %0d: rd=%h want %h", u, got, dout_rd[u], exp);
            end
          end
          got++;
        end else begin
          stalled = 1'b1;
          hold    = dout_rd[u];
        end
      end
      @(posedge clock); #1;
      cyc++;
    end
    total++;
    if (sent != nops || got != nops || q.size() != 0) begin
      bad++;
      $display("FAIL bp u%0d count: sent=%0d got=%0d pending=%0d, want %0d %0d 0", u, sent, got, q.size(), nops, nops);
    end
    din_valid[u]  = 1'b0;
    dout_ready[u] = 1'b0;
    din_insn14[u] = 1'b0;
  endtask

`ifdef RVB_BMATFLIP_ANTI_EN
  task automatic test_anti();
    for (int u = 0; u < 3; u += 2) begin
      do_op(u, 64'h1,  1'b1, 64'h8000000000000000, $sformatf("anti u%0d bit0", u));
      do_op(u, 64'h80, 1'b1, 64'h0000000000000080, $sformatf("anti u%0d bit7", u));
      do_op(u, 64'h80, 1'b0, 64'h0100000000000000, $sformatf("anti u%0d normal", u));
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      din_valid[u]  = 1'b0;
      din_insn14[u] = 1'b0;
      dout_ready[u] = 1'b0;
      din_rs1[u]    = '0;
      din_rs2[u]    = '0;
    end
    test_reset();
    test_single();
    test_latency();
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_mid();
`ifdef RVB_BMATFLIP_ANTI_EN
    test_anti();
`endif
    for (int u = 0; u < 3; u++) test_backpressure(u, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvb_bmatflip.md
Name: rvb_bmatflip

Overview:
- 64-bit bit-matrix transpose unit (8x8 bit matrix held in rs1), responder on the same din/dout valid-ready protocol as the other rvb_bmat* units.
- Sits beside rvb_bmatxor in the bitmanip execute cluster, driven by the same issue logic.
- Selectable single-cycle or iterative (byte-sliced) implementation, trading area against latency.

Parameters:
- CYCLES, 0, 0 = one registered stage. 1/2/4/8 = iterative, producing 8/CYCLES result bytes per cycle. Any other value is an elaboration error.
- XLEN, 64, data width. Fixed at 64; any other value is an elaboration error.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- din_valid  in  1  request valid
- din_ready  out  1  request accepted when din_valid && din_ready at posedge
- din_rs1  in  64  source matrix; byte i = row i, bit j = column j
- din_rs2  in  64  unused; kept for port compatibility with rvb_bmatxor
- din_insn14  in  1  variant select; only used with the optional feature
- dout_valid  out  1  result valid
- dout_ready  in  1  result consumed when dout_valid && dout_ready at posedge
- dout_rd  out  64  result

Behaviour:
- Function: rd.byte[i].bit[j] = rs1.byte[j].bit[i], for i,j in 0..7.
- Reset (synchronous, active-high):
  - dout_valid=0, dout_rd=0, state=IDLE, slice counter=0.
  - Any in-flight operation is discarded.
  - din_ready=1 in the cycle after reset deasserts.
- CYCLES=0:
  - No FSM.
  - din_ready = !dout_valid || dout_ready (combinational).
  - On accept: dout_rd <= transpose(din_rs1), dout_valid <= 1 at the same edge. Latency 1 cycle.
  - Simultaneous accept and consume: the new result replaces the old one; dout_valid stays 1. Throughput 1 per cycle.
  - Consume without accept: dout_valid <= 0.
- CYCLES=N (1/2/4/8): FSM with three states.
  - IDLE: din_ready=1. On accept: latch rs1 (and insn14), counter <= 0, clear dout_rd, go to BUSY.
  - BUSY: din_ready=0, dout_valid=0.
    - Each cycle write result bytes [counter*8/N +: 8/N], then counter++.
    - When counter==N-1, go to DONE with dout_valid <= 1.
  - DONE: dout_valid=1, din_ready = dout_ready.
    - Consume without accept: go to IDLE.
    - Consume with accept: latch the new operand and go to BUSY; dout_valid drops at the same edge.
  - Latency: accept at edge k -> dout_valid high after edge k+N.
  - Result bytes not yet computed read 0 while BUSY (not observable, since dout_valid=0).
- Input stability:
  - din_rs1 and din_insn14 are sampled only on the accept edge.
  - The initiator may drop din_valid at any time without effect while din_ready=0.
- dout_rd stays stable while dout_valid && !dout_ready.
- Counter width is $clog2(CYCLES)+1 bits; no wrap is possible because the counter resets on every accept.
- Reset takes priority over a simultaneous accept or consume.

Optional Feature:
- Macro: RVB_BMATFLIP_ANTI_EN.
- Defined: din_insn14=1 selects the anti-transpose rd.byte[i].bit[j] = rs1.byte[7-j].bit[7-i]. insn14 is latched with rs1. din_insn14=0 gives the normal transpose.
- Undefined: din_insn14 is ignored and every request performs the normal transpose. No extra logic is generated.

Decomposition:
- Shared package rvb_pkg:
  - XLEN
  - FSM state enum (IDLE/BUSY/DONE), shared with the other iterative rvb units
  - legal-CYCLES check constant
- One sub-module, rvb_bmatflip_slice:
  - Combinational; given the 64-bit matrix, a slice index, and the anti flag, returns the selected result bytes.
  - Instantiated once.
  - CYCLES=0 uses it with a full 8-byte slice.

Test Plan:
- Single transposes, CYCLES=0 and CYCLES=8 instances:
  - rs1=0x0000000000000001 -> rd=0x0000000000000001
  - rs1=0x0000000000000080 -> rd=0x0100000000000000
  - rs1=0x00000000000000FF -> rd=0x0101010101010101
  - rs1=0x8040201008040201 -> rd unchanged
- Latency: CYCLES=4, dout_ready tied 1, accept at edge k -> dout_valid first high after edge k+4. din_ready=0 on edges k+1..k+4.
- Backpressure:
  - 1000 random operands, din_valid random 75%, dout_ready random 87.5%.
  - Every result matches a reference-model transpose, in order, with none lost or duplicated.
  - dout_rd stays stable while stalled.
- Back-to-back in DONE: dout_ready=1 and din_valid=1 while DONE -> the new operand is accepted on the consume edge; the next result appears N cycles later.
- Reset mid-operation: CYCLES=8, assert reset at counter=3 -> dout_valid=0 next cycle and no stale result ever appears. The next request (rs1=0xFF) returns 0x0101010101010101.
- With RVB_BMATFLIP_ANTI_EN defined:
  - insn14=1, rs1=0x0000000000000001 -> rd=0x8000000000000000
  - insn14=1, rs1=0x0000000000000080 -> rd=0x0000000000000080
  - insn14=0 -> normal transpose
